// File: rtl/vga_pixel_scheduler_if.sv
// Pixel-scheduler bus: sprite-layer requests/colours in, VGA timing, coordinates and pixel word out.
interface vga_pixel_scheduler_if;
   logic [2:0] layer_req;
   logic [7:0] layer0_rgb;
   logic [7:0] layer1_rgb;
   logic [7:0] layer2_rgb;
   logic [7:0] bg_rgb;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic       pix_tick;
   logic       active;
   logic       hsync;
   logic       vsync;
   logic       frame_start;
   logic [7:0] rgb_out;

   modport master (
      input  layer_req, layer0_rgb, layer1_rgb, layer2_rgb, bg_rgb,
      output pix_x, pix_y, pix_tick, active, hsync, vsync, frame_start, rgb_out
   );

   modport slave (
      output layer_req, layer0_rgb, layer1_rgb, layer2_rgb, bg_rgb,
      input  pix_x, pix_y, pix_tick, active, hsync, vsync, frame_start, rgb_out
   );
endinterface

// File: rtl/vga_pixel_scheduler.sv
// VGA timing generator plus fixed-priority sprite/background arbiter producing a registered RRRGGGBB word.
// Optional feature: define TEST_PATTERN_EN to add a test_mode input selecting 8 vertical colour bars.
module vga_pixel_scheduler #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic clk,
   input  logic rst,
`ifdef TEST_PATTERN_EN
   input  logic test_mode,
`endif
   vga_pixel_scheduler_if.master vga
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_FP_AT  = 10'(H_ACTIVE);
   localparam logic [9:0] H_SY_AT  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_BP_AT  = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_FP_AT  = 10'(V_ACTIVE);
   localparam logic [9:0] V_SY_AT  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_BP_AT  = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {REG_ACTIVE, REG_FRONT, REG_SYNC, REG_BACK} region_t;

   function automatic region_t region_of(input logic [9:0] cnt, input logic [9:0] fp_at,
                                         input logic [9:0] sy_at, input logic [9:0] bp_at);
      if (cnt < fp_at)      return REG_ACTIVE;
      else if (cnt < sy_at) return REG_FRONT;
      else if (cnt < bp_at) return REG_SYNC;
      else                  return REG_BACK;
   endfunction

   logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
   logic [9:0]       h_cnt_reg, h_cnt_next;
   logic [9:0]       v_cnt_reg, v_cnt_next;
   region_t          h_region_reg, h_region_next;
   region_t          v_region_reg, v_region_next;
   logic             active_reg, active_next;
   logic             hsync_reg, hsync_next;
   logic             vsync_reg, vsync_next;
   logic             frame_start_reg, frame_start_next;
   logic [7:0]       rgb_out_reg, rgb_out_next;
   logic             tick;
   logic             h_wrap, v_wrap, blank;
   logic [7:0]       pixel_rgb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_reg     <= '0;
         h_cnt_reg       <= '0;
         v_cnt_reg       <= '0;
         h_region_reg    <= REG_ACTIVE;
         v_region_reg    <= REG_ACTIVE;
         active_reg      <= 1'b0;
         hsync_reg       <= 1'b1;
         vsync_reg       <= 1'b1;
         frame_start_reg <= 1'b0;
         rgb_out_reg     <= 8'h00;
      end else begin
         div_cnt_reg     <= div_cnt_next;
         h_cnt_reg       <= h_cnt_next;
         v_cnt_reg       <= v_cnt_next;
         h_region_reg    <= h_region_next;
         v_region_reg    <= v_region_next;
         active_reg      <= active_next;
         hsync_reg       <= hsync_next;
         vsync_reg       <= vsync_next;
         frame_start_reg <= frame_start_next;
         rgb_out_reg     <= rgb_out_next;
      end
   end

   always_comb begin
      // Masked by rst so the strobe reads 0 during reset even when CLK_DIV=1.
      tick   = (div_cnt_reg == DIV_LAST) && !rst;
      h_wrap = (h_cnt_reg == H_LAST);
      v_wrap = (v_cnt_reg == V_LAST);

      div_cnt_next = tick ? '0 : div_cnt_reg + DIV_W'(1);
      h_cnt_next   = h_cnt_reg;
      v_cnt_next   = v_cnt_reg;
      if (tick) begin
         h_cnt_next = h_wrap ? 10'd0 : h_cnt_reg + 10'd1;
         if (h_wrap) v_cnt_next = v_wrap ? 10'd0 : v_cnt_reg + 10'd1;
      end

      // Region registers always track the counter value they will sit beside.
      h_region_next = region_of(h_cnt_next, H_FP_AT, H_SY_AT, H_BP_AT);
      v_region_next = region_of(v_cnt_next, V_FP_AT, V_SY_AT, V_BP_AT);
      blank = (h_region_reg != REG_ACTIVE) || (v_region_reg != REG_ACTIVE);

      pixel_rgb = vga.bg_rgb;
      if (vga.layer_req[0])      pixel_rgb = vga.layer0_rgb;
      else if (vga.layer_req[1]) pixel_rgb = vga.layer1_rgb;
      else if (vga.layer_req[2]) pixel_rgb = vga.layer2_rgb;
`ifdef TEST_PATTERN_EN
      if (test_mode) begin
         case (h_cnt_reg / 10'd80)
            10'd0:   pixel_rgb = 8'hFF;
            10'd1:   pixel_rgb = 8'hFC;
            10'd2:   pixel_rgb = 8'h1F;
            10'd3:   pixel_rgb = 8'h1C;
            10'd4:   pixel_rgb = 8'hE3;
            10'd5:   pixel_rgb = 8'hE0;
            10'd6:   pixel_rgb = 8'h03;
            default: pixel_rgb = 8'h00;
         endcase
      end
`endif

      active_next      = active_reg;
      hsync_next       = hsync_reg;
      vsync_next       = vsync_reg;
      rgb_out_next     = rgb_out_reg;
      frame_start_next = tick && h_wrap && v_wrap;
      if (tick) begin
         active_next  = !blank;
         hsync_next   = (h_region_reg != REG_SYNC);
         vsync_next   = (v_region_reg != REG_SYNC);
         rgb_out_next = blank ? 8'h00 : pixel_rgb;
      end
   end

   assign vga.pix_x       = h_cnt_reg;
   assign vga.pix_y       = v_cnt_reg;
   assign vga.pix_tick    = tick;
   assign vga.active      = active_reg;
   assign vga.hsync       = hsync_reg;
   assign vga.vsync       = vsync_reg;
   assign vga.frame_start = frame_start_reg;
   assign vga.rgb_out     = rgb_out_reg;
endmodule

// File: tb/tb_vga_pixel_scheduler.sv
// Directed bench for vga_pixel_scheduler: default horizontal timing, shortened vertical timing (17 lines).
module tb_vga_pixel_scheduler;
   localparam int V_ACTIVE    = 12;
   localparam int FRAME_TICKS = 800 * 17;
   localparam int NV          = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef TEST_PATTERN_EN
   logic test_mode = 1'b0;
`endif

   vga_pixel_scheduler_if vif ();

   vga_pixel_scheduler #(
      .CLK_DIV(2), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_ACTIVE(V_ACTIVE), .V_FP(2), .V_SYNC(2), .V_BP(1)
   ) dut (
      .clk(clk),
      .rst(rst),
`ifdef TEST_PATTERN_EN
      .test_mode(test_mode),
`endif
      .vga(vif)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Directed pixel vectors: coordinate, request, background, expected rgb_out/active.
   int         vec_x   [NV] = '{0, 10, 11, 12, 13, 14, 15, 639, 640, 799, 5, 0};
   int         vec_y   [NV] = '{0, 10, 10, 10, 10, 10, 10, 10, 10, 11, 12, 11};
   logic [2:0] vec_req [NV] = '{3'b001, 3'b110, 3'b000, 3'b111, 3'b100, 3'b010, 3'b000,
                                3'b001, 3'b001, 3'b111, 3'b001, 3'b001};
   logic [7:0] vec_bg  [NV] = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h1F,
                                8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
   logic [7:0] vec_rgb [NV] = '{8'hE3, 8'hE0, 8'h03, 8'hE3, 8'h1C, 8'hE0, 8'h1F,
                                8'hE3, 8'h00, 8'h00, 8'h00, 8'hE3};
   logic       vec_act [NV] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   int         px, py, vec_hit;
   logic       vec_en = 1'b1;
   logic       s_hs, s_vs, s_act, s_fs;
   logic [7:0] s_rgb;

   task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Advance one pixel: drive inputs for the coordinate being ticked, then sample its registered outputs.
   task automatic step_pixel();
      int waited;
      waited  = 0;
      vec_hit = -1;
      @(negedge clk);
      while (vif.pix_tick !== 1'b1 && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      if (vif.pix_tick !== 1'b1) begin
         check_eq("tick_timeout", 32'(vif.pix_tick), 32'd1);
         return;
      end
      px = int'(vif.pix_x);
      py = int'(vif.pix_y);
      vif.layer_req = 3'b000;
      vif.bg_rgb    = 8'h03;
      if (vec_en)
         for (int i = 0; i < NV; i++)
            if (vec_x[i] == px && vec_y[i] == py) vec_hit = i;
      if (vec_hit >= 0) begin
         vif.layer_req = vec_req[vec_hit];
         vif.bg_rgb    = vec_bg[vec_hit];
      end
      @(posedge clk);
      #1;
      s_hs  = vif.hsync;
      s_vs  = vif.vsync;
      s_act = vif.active;
      s_fs  = vif.frame_start;
      s_rgb = vif.rgb_out;
      if (vec_hit >= 0) begin
         check_eq($sformatf("rgb(%0d,%0d)", px, py), 32'(s_rgb), 32'(vec_rgb[vec_hit]));
         check_eq($sformatf("active(%0d,%0d)", px, py), 32'(s_act), 32'(vec_act[vec_hit]));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_pix_x"}, 32'(vif.pix_x), 32'd0);
      check_eq({tag, "_pix_y"}, 32'(vif.pix_y), 32'd0);
      check_eq({tag, "_pix_tick"}, 32'(vif.pix_tick), 32'd0);
      check_eq({tag, "_active"}, 32'(vif.active), 32'd0);
      check_eq({tag, "_hsync"}, 32'(vif.hsync), 32'd1);
      check_eq({tag, "_vsync"}, 32'(vif.vsync), 32'd1);
      check_eq({tag, "_frame_start"}, 32'(vif.frame_start), 32'd0);
      check_eq({tag, "_rgb_out"}, 32'(vif.rgb_out), 32'd0);
   endtask

   // Step until frame_start, returning how many pixel ticks that took.
   task automatic run_to_frame_start(output int steps);
      steps = 0;
      do begin
         step_pixel();
         steps++;
      end while (!s_fs && steps < FRAME_TICKS + 100);
   endtask

   initial begin
      int steps, hs_low, hs_first, vs_lines, vs_first, act_cnt, bad_px;
      logic exp_act;

      vif.layer_req  = 3'b000;
      vif.layer0_rgb = 8'hE3;
      vif.layer1_rgb = 8'hE0;
      vif.layer2_rgb = 8'h1C;
      vif.bg_rgb     = 8'h03;

      // Reset held 5 clk, released on a falling edge.
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("in_reset");
      rst = 1'b0;
      #1;
      check_reset_outputs("after_release");
      @(posedge clk);
      #1;
      check_eq("first_tick_2nd_clk", 32'(vif.pix_tick), 32'd1);
      check_eq("first_tick_x", 32'(vif.pix_x), 32'd0);

      // One full frame from reset: timing, arbitration vectors and blanking.
      steps = 0; hs_low = 0; hs_first = -1; vs_lines = 0; vs_first = -1; act_cnt = 0; bad_px = 0;
      do begin
         step_pixel();
         steps++;
         if (py == 0 && !s_hs) begin
            hs_low++;
            if (hs_first < 0) hs_first = px;
         end
         if (px == 0 && !s_vs) begin
            vs_lines++;
            if (vs_first < 0) vs_first = py;
         end
         if (s_act) act_cnt++;
         if (vec_hit < 0) begin
            exp_act = (px < 640) && (py < V_ACTIVE);
            if (s_act !== exp_act || s_rgb !== (exp_act ? 8'h03 : 8'h00)) bad_px++;
         end
      end while (!s_fs && steps < FRAME_TICKS + 100);
      check_eq("frame_ticks", 32'(steps), 32'(FRAME_TICKS));
      check_eq("fs_from_x", 32'(px), 32'd799);
      check_eq("fs_from_y", 32'(py), 32'd16);
      check_eq("fs_now_x", 32'(vif.pix_x), 32'd0);
      check_eq("fs_now_y", 32'(vif.pix_y), 32'd0);
      check_eq("hsync_low_ticks", 32'(hs_low), 32'd96);
      check_eq("hsync_low_from", 32'(hs_first), 32'd656);
      check_eq("vsync_low_lines", 32'(vs_lines), 32'd2);
      check_eq("vsync_low_from", 32'(vs_first), 32'd14);
      check_eq("active_ticks", 32'(act_cnt), 32'(640 * V_ACTIVE));
      check_eq("bg_blank_pixels_bad", 32'(bad_px), 32'd0);
      @(posedge clk);
      #1;
      check_eq("fs_one_clk", 32'(vif.frame_start), 32'd0);

      // Asynchronous reset mid-line at (300,5).
      steps = 0;
      do begin
         step_pixel();
         steps++;
      end while (!(px == 300 && py == 5) && steps < FRAME_TICKS);
      check_eq("pre_rst_active", 32'(s_act), 32'd1);
      check_eq("pre_rst_rgb", 32'(s_rgb), 32'h03);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_line_rst");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      run_to_frame_start(steps);
      check_eq("frame_ticks_after_rst", 32'(steps), 32'(FRAME_TICKS));

`ifdef TEST_PATTERN_EN
      // Colour bars on line 0.
      vec_en    = 1'b0;
      test_mode = 1'b1;
      steps     = 0;
      do begin
         step_pixel();
         steps++;
         case (px)
            0:   check_eq("bar_x0",   32'(s_rgb), 32'hFF);
            79:  check_eq("bar_x79",  32'(s_rgb), 32'hFF);
            80:  check_eq("bar_x80",  32'(s_rgb), 32'hFC);
            160: check_eq("bar_x160", 32'(s_rgb), 32'h1F);
            559: check_eq("bar_x559", 32'(s_rgb), 32'h03);
            560: check_eq("bar_x560", 32'(s_rgb), 32'h00);
            639: check_eq("bar_x639", 32'(s_rgb), 32'h00);
            640: check_eq("bar_x640_blank", 32'(s_act), 32'd0);
            default: ;
         endcase
      end while (px != 641 && steps < 800);
      test_mode = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
